branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Multi-cycle sequencer that resolves one decoded B-type branch at a time.
//  Accepts rs1/rs2/imm/branch_control from the branch decoder plus the branch PC, and arbitrates
//  for the shared register-file read port. It then evaluates the condition and returns a
//  redirect (taken target or PC+4) to fetch. Sits between decode and fetch; keeps saturating
//  branch/taken performance counters.
// PARAMETERS
//  XLEN    32  datapath / PC width
//  IALIGN  32  instruction alignment in bits (32: target[1:0]!=0 misaligned; 16: target[0] only)
//  CNT_W   16  width of each performance counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  br_valid       in   1      decoded branch offered
//  br_ready       out  1      block can accept a branch
//  br_pc          in   XLEN   PC of the branch instruction
//  br_rs1         in   5      source register 1
//  br_rs2         in   5      source register 2
//  br_imm         in   13     B-type immediate, bit0 always 0
//  br_ctrl        in   3      branch_control (funct3 encoding)
//  rf_req         out  1      request for shared RF read port
//  rf_gnt         in   1      grant; rf_data valid the cycle after grant
//  rf_addr1       out  5      read address 1 (=rs1, stable while rf_req)
//  rf_addr2       out  5      read address 2 (=rs2, stable while rf_req)
//  rf_data1       in   XLEN   read data 1
//  rf_data2       in   XLEN   read data 2
//  resp_valid     out  1      resolution result available
//  resp_ready     in   1      fetch accepts result
//  resp_taken     out  1      condition true
//  resp_pc        out  XLEN   next PC: br_pc+sext(imm) if taken else br_pc+4
//  resp_misalign  out  1      taken target violates IALIGN (exception; resp_pc = target)
//  resp_illegal   out  1      br_ctrl is 010 or 011; taken=0, resp_pc=br_pc+4
//  flush          in   1      abort in-flight branch
//  cnt_clr        in   1      synchronous clear of both counters
//  cnt_branches   out  CNT_W  resolved branches (saturating)
//  cnt_taken      out  CNT_W  resolved taken branches (saturating)
// BEHAVIOUR
//  Reset: state IDLE; br_ready=1, rf_req=0, resp_valid=0, all resp_* = 0, rf_addr*=0, counters=0.
//  FSM IDLE->REQ->WAIT->RESP->IDLE; br_ready = (state==IDLE) & ~flush.
//  IDLE: on br_valid&br_ready, latch pc/rs1/rs2/imm/ctrl; go to REQ.
//  REQ: rf_req=1 until rf_gnt; on gnt go to WAIT, drop rf_req the next cycle.
//  WAIT: capture rf_data1/2, forcing 0 for x0 operands; compute the result; register resp_*; go to RESP.
//  RESP: resp_valid=1, resp_* held stable until resp_valid&resp_ready; then go to IDLE.
//  Minimum latency: accept at N, rf_req at N+1 (gnt at N+1), capture at N+2, resp_valid at N+3.
//  Conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
//  Target = br_pc + sext(br_imm) mod 2^XLEN (wraps silently); fallthrough = br_pc+4 mod 2^XLEN.
//  misalign is evaluated only when taken. Illegal ctrl still consumes the full RF sequence.
//  Flush: from any state, next state IDLE; rf_req and resp_valid drop next cycle; result discarded.
//   A gnt coinciding with flush is consumed and ignored.
//   resp handshake in the same cycle as flush completes and counts.
//   br_valid during flush is not accepted.
//  Counters increment on the resp handshake (taken adds to both); hold at 2^CNT_W-1.
//  cnt_clr has priority over increment. Counters are not affected by flush or illegal status.
//  Reset asserted mid-operation: immediate return to reset values; no partial response.
// STRUCTURE
//  Package branch_pkg: typedef enum logic[2:0] br_ctrl_e (BEQ..BGEU), state enum, IALIGN checks.
//  One sub-module: branch_cmp (combinational: a, b, ctrl -> taken, illegal); FSM, target
//  adder and counters live in branch_resolve_ctrl.
// TESTING
//  BEQ x1=5,x2=5, pc=0x100, imm=0x010, gnt immediate -> resp at N+3, taken=1, resp_pc=0x110.
//  BLT x1=0xFFFFFFFF, x2=1 -> taken=1; BLTU same operands -> taken=0, resp_pc=pc+4.
//  gnt withheld 4 cycles, resp_ready low 3 cycles -> rf_req/addr and resp_* stable throughout.
//  pc=0x0, imm=-4 (0x1FFC), BNE 1,2 -> resp_pc=0xFFFFFFFC; imm=0x002, IALIGN=32 -> misalign=1.
//  br_ctrl=010 -> resp_illegal=1, taken=0; flush in WAIT -> no resp_valid, counters unchanged.
//  Counters CNT_W=2: 4 taken branches -> both saturate at 3; cnt_clr plus handshake -> 0.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and the instruction-alignment check for the branch resolver.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } br_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    // IALIGN=16 (compressed) only needs halfword alignment.
    function automatic logic misaligned(input logic [1:0] lo, input int ialign);
        return (ialign == 16) ? lo[0] : |lo;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational B-type condition evaluation; reserved encodings flag illegal.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  br_ctrl_e        ctrl,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        illegal = (ctrl == BR_RSV2) || (ctrl == BR_RSV3);
        case (ctrl)
            BR_EQ:   taken = a == b;
            BR_NE:   taken = a != b;
            BR_LT:   taken = $signed(a) < $signed(b);
            BR_GE:   taken = $signed(a) >= $signed(b);
            BR_LTU:  taken = a < b;
            BR_GEU:  taken = a >= b;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences one branch through RF read, condition evaluation and
// redirect handshake to fetch, with saturating branch/taken counters.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [4:0]       br_rs1,
    input  logic [4:0]       br_rs2,
    input  logic [12:0]      br_imm,
    input  logic [2:0]       br_ctrl,
    output logic             rf_req,
    input  logic             rf_gnt,
    output logic [4:0]       rf_addr1,
    output logic [4:0]       rf_addr2,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_taken,
    output logic [XLEN-1:0]  resp_pc,
    output logic             resp_misalign,
    output logic             resp_illegal,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_taken
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d;
    logic [12:0]       imm_q, imm_d;
    br_ctrl_e          ctrl_q, ctrl_d;
    logic              rf_req_q, rf_req_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_taken_q, resp_taken_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic              resp_misalign_q, resp_misalign_d;
    logic              resp_illegal_q, resp_illegal_d;
    logic [CNT_W-1:0]  cnt_br_q, cnt_br_d, cnt_tk_q, cnt_tk_d;

    logic [XLEN-1:0]   op1, op2, target, fallthrough;
    logic              taken, illegal, hs;

    // x0 always reads as zero regardless of what the shared port returns.
    assign op1         = (rs1_q == 5'd0) ? '0 : rf_data1;
    assign op2         = (rs2_q == 5'd0) ? '0 : rf_data2;
    assign target      = pc_q + {{(XLEN-13){imm_q[12]}}, imm_q};
    assign fallthrough = pc_q + XLEN'(4);
    assign hs          = resp_valid_q & resp_ready;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a       (op1),
        .b       (op2),
        .ctrl    (ctrl_q),
        .taken   (taken),
        .illegal (illegal)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        imm_d           = imm_q;
        ctrl_d          = ctrl_q;
        rf_req_d        = rf_req_q;
        resp_valid_d    = resp_valid_q;
        resp_taken_d    = resp_taken_q;
        resp_pc_d       = resp_pc_q;
        resp_misalign_d = resp_misalign_q;
        resp_illegal_d  = resp_illegal_q;
        case (state_q)
            S_IDLE: if (br_valid && br_ready) begin
                pc_d     = br_pc;
                rs1_d    = br_rs1;
                rs2_d    = br_rs2;
                imm_d    = br_imm;
                ctrl_d   = br_ctrl_e'(br_ctrl);
                rf_req_d = 1'b1;
                state_d  = S_REQ;
            end
            S_REQ: if (rf_gnt) begin
                rf_req_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                resp_valid_d    = 1'b1;
                resp_taken_d    = taken;
                resp_pc_d       = taken ? target : fallthrough;
                resp_misalign_d = taken && misaligned(target[1:0], IALIGN);
                resp_illegal_d  = illegal;
                state_d         = S_RESP;
            end
            S_RESP: if (resp_ready) begin
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d      = S_IDLE;
            rf_req_d     = 1'b0;
            resp_valid_d = 1'b0;
        end
    end

    // A handshake coinciding with flush still counts; clear wins over increment.
    always_comb begin
        cnt_br_d = cnt_clr ? '0 : (hs && cnt_br_q != '1) ? cnt_br_q + CNT_W'(1) : cnt_br_q;
        cnt_tk_d = cnt_clr ? '0 : (hs && resp_taken_q && cnt_tk_q != '1) ? cnt_tk_q + CNT_W'(1) : cnt_tk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            pc_q            <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            imm_q           <= '0;
            ctrl_q          <= BR_EQ;
            rf_req_q        <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_taken_q    <= 1'b0;
            resp_pc_q       <= '0;
            resp_misalign_q <= 1'b0;
            resp_illegal_q  <= 1'b0;
            cnt_br_q        <= '0;
            cnt_tk_q        <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            imm_q           <= imm_d;
            ctrl_q          <= ctrl_d;
            rf_req_q        <= rf_req_d;
            resp_valid_q    <= resp_valid_d;
            resp_taken_q    <= resp_taken_d;
            resp_pc_q       <= resp_pc_d;
            resp_misalign_q <= resp_misalign_d;
            resp_illegal_q  <= resp_illegal_d;
            cnt_br_q        <= cnt_br_d;
            cnt_tk_q        <= cnt_tk_d;
        end
    end

    assign br_ready      = (state_q == S_IDLE) && !flush;
    assign rf_req        = rf_req_q;
    assign rf_addr1      = rs1_q;
    assign rf_addr2      = rs2_q;
    assign resp_valid    = resp_valid_q;
    assign resp_taken    = resp_taken_q;
    assign resp_pc       = resp_pc_q;
    assign resp_misalign = resp_misalign_q;
    assign resp_illegal  = resp_illegal_q;
    assign cnt_branches  = cnt_br_q;
    assign cnt_taken     = cnt_tk_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized checks against a transaction-level model.
module tb_branch_resolve_ctrl;

    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0, br_ready;
    logic [31:0] br_pc = '0;
    logic [4:0]  br_rs1 = '0, br_rs2 = '0;
    logic [12:0] br_imm = '0;
    logic [2:0]  br_ctrl = '0;
    logic        rf_req, rf_gnt = 1'b0;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_data1 = '0, rf_data2 = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_taken, resp_misalign, resp_illegal;
    logic [31:0] resp_pc;
    logic        flush = 1'b0, cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_branches, cnt_taken;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.XLEN(32), .IALIGN(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc),
        .br_rs1(br_rs1), .br_rs2(br_rs2), .br_imm(br_imm), .br_ctrl(br_ctrl),
        .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_taken(resp_taken), .resp_pc(resp_pc), .resp_misalign(resp_misalign),
        .resp_illegal(resp_illegal), .flush(flush), .cnt_clr(cnt_clr),
        .cnt_branches(cnt_branches), .cnt_taken(cnt_taken)
    );

    logic [31:0] regs [32];
    int total = 0, bad = 0;

    // Transaction-level model: which phases of the one in-flight branch are outstanding.
    bit m_busy, m_need, m_data, m_pend;
    logic [31:0] t_pc;
    logic [4:0]  t_rs1, t_rs2;
    logic [12:0] t_imm;
    logic [2:0]  t_ctrl;
    bit          e_taken, e_mis, e_ill;
    logic [31:0] e_pc;
    int          m_cb, m_ct;

    bit          got_taken, got_mis, got_ill;
    logic [31:0] got_pc;
    int          lat;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void resolve();
        logic [31:0] a, b, tgt;
        int off;
        bit c;
        a = (t_rs1 == 0) ? 32'd0 : regs[t_rs1];
        b = (t_rs2 == 0) ? 32'd0 : regs[t_rs2];
        off = t_imm[12] ? int'(t_imm) - 8192 : int'(t_imm);
        tgt = t_pc + 32'(off);
        case (t_ctrl)
            3'd0: c = a == b;
            3'd1: c = a != b;
            3'd4: c = $signed(a) < $signed(b);
            3'd5: c = $signed(a) >= $signed(b);
            3'd6: c = a < b;
            3'd7: c = a >= b;
            default: c = 1'b0;
        endcase
        e_ill   = (t_ctrl == 3'd2) || (t_ctrl == 3'd3);
        e_taken = c;
        e_pc    = c ? tgt : t_pc + 32'd4;
        e_mis   = c && (tgt % 4 != 0);
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_need = 0; m_data = 0; m_pend = 0; m_cb = 0; m_ct = 0;
    endfunction

    // Called at a negedge with inputs already set; checks this cycle and advances the model.
    task automatic step();
        bit hs, acc;
        rf_data1 = m_data ? regs[t_rs1] : $urandom;
        rf_data2 = m_data ? regs[t_rs2] : $urandom;
        #1;
        chk("br_ready", 64'(br_ready), 64'(!m_busy && !flush));
        chk("rf_req", 64'(rf_req), 64'(m_need));
        if (m_need) begin
            chk("rf_addr1", 64'(rf_addr1), 64'(t_rs1));
            chk("rf_addr2", 64'(rf_addr2), 64'(t_rs2));
        end
        chk("resp_valid", 64'(resp_valid), 64'(m_pend));
        if (m_pend) begin
            chk("resp_taken", 64'(resp_taken), 64'(e_taken));
            chk("resp_pc", 64'(resp_pc), 64'(e_pc));
            chk("resp_misalign", 64'(resp_misalign), 64'(e_mis));
            chk("resp_illegal", 64'(resp_illegal), 64'(e_ill));
        end
        chk("cnt_branches", 64'(cnt_branches), 64'(m_cb));
        chk("cnt_taken", 64'(cnt_taken), 64'(m_ct));
        hs  = m_pend && resp_ready;
        acc = br_valid && !m_busy && !flush;
        if (cnt_clr) begin
            m_cb = 0; m_ct = 0;
        end else if (hs) begin
            if (m_cb < CMAX) m_cb++;
            if (e_taken && m_ct < CMAX) m_ct++;
        end
        if (flush) begin
            m_busy = 0; m_need = 0; m_data = 0; m_pend = 0;
        end else begin
            if (m_data) begin
                resolve();
                m_pend = 1; m_data = 0;
            end else if (hs) begin
                m_pend = 0; m_busy = 0;
            end
            if (m_need && rf_gnt) begin
                m_need = 0; m_data = 1;
            end
            if (acc) begin
                m_busy = 1; m_need = 1;
                t_pc = br_pc; t_rs1 = br_rs1; t_rs2 = br_rs2; t_imm = br_imm; t_ctrl = br_ctrl;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_br(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [12:0] imm, input logic [2:0] ctrl,
                          input int gd, input int rd, input bit clr_hs);
        int g, r;
        br_valid = 1; br_pc = pc; br_rs1 = r1; br_rs2 = r2; br_imm = imm; br_ctrl = ctrl;
        rf_gnt = 0; resp_ready = 0;
        step();
        br_valid = 0; br_pc = $urandom; br_rs1 = 5'($urandom); br_rs2 = 5'($urandom);
        br_ctrl = 3'($urandom);
        lat = -1; g = 0; r = 0;
        for (int k = 1; k < 60; k++) begin
            rf_gnt = rf_req && g >= gd;
            if (rf_req) g++;
            resp_ready = resp_valid && r >= rd;
            cnt_clr = resp_ready && clr_hs;
            if (resp_valid) begin
                if (lat < 0) begin
                    lat = k; got_taken = resp_taken; got_pc = resp_pc;
                    got_mis = resp_misalign; got_ill = resp_illegal;
                end
                r++;
            end
            step();
            if (lat >= 0 && resp_ready) break;
        end
        rf_gnt = 0; resp_ready = 0; cnt_clr = 0;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL resp_timeout: got no response want resp_valid within 60 cycles");
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEADBEEF; regs[1] = 5; regs[2] = 5; regs[3] = 32'hFFFFFFFF;
        regs[4] = 1; regs[5] = 32'h80000000; regs[6] = 2; regs[7] = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_br_ready", 64'(br_ready), 1);
        chk("rst_rf_req", 64'(rf_req), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_pc", 64'(resp_pc), 0);
        chk("rst_resp_flags", 64'({resp_taken, resp_misalign, resp_illegal}), 0);
        chk("rst_rf_addr", 64'({rf_addr1, rf_addr2}), 0);
        chk("rst_cnt", 64'({cnt_branches, cnt_taken}), 0);
        rst_n = 1;
        @(negedge clk);

        run_br(32'h100, 1, 2, 13'h010, 3'd0, 0, 0, 0);
        chk("beq_latency", 64'(lat), 3);
        chk("beq_taken", 64'(got_taken), 1);
        chk("beq_pc", 64'(got_pc), 64'h110);
        run_br(32'h200, 3, 4, 13'h020, 3'd4, 0, 0, 0);
        chk("blt_taken", 64'(got_taken), 1);
        chk("blt_pc", 64'(got_pc), 64'h220);
        run_br(32'h200, 3, 4, 13'h020, 3'd6, 0, 0, 0);
        chk("bltu_taken", 64'(got_taken), 0);
        chk("bltu_pc", 64'(got_pc), 64'h204);
        run_br(32'h300, 5, 4, 13'h040, 3'd5, 4, 3, 0);
        chk("bge_stall_latency", 64'(lat), 7);
        chk("bge_taken", 64'(got_taken), 0);
        chk("bge_pc", 64'(got_pc), 64'h304);
        run_br(32'h0, 4, 6, 13'h1FFC, 3'd1, 0, 0, 0);
        chk("wrap_pc", 64'(got_pc), 64'hFFFFFFFC);
        chk("wrap_misalign", 64'(got_mis), 0);
        run_br(32'h0, 4, 6, 13'h002, 3'd1, 0, 0, 0);
        chk("mis_pc", 64'(got_pc), 64'h2);
        chk("mis_flag", 64'(got_mis), 1);
        run_br(32'h400, 1, 2, 13'h010, 3'd2, 0, 0, 0);
        chk("ill_flag", 64'(got_ill), 1);
        chk("ill_taken", 64'(got_taken), 0);
        chk("ill_pc", 64'(got_pc), 64'h404);
        run_br(32'h500, 0, 7, 13'h008, 3'd1, 0, 0, 0);
        chk("x0_taken", 64'(got_taken), 0);

        // Flush while the read data is being captured.
        cnt_clr = 1; step(); cnt_clr = 0;
        chk("clr_cnt", 64'({cnt_branches, cnt_taken}), 0);
        br_valid = 1; br_pc = 32'h600; br_rs1 = 1; br_rs2 = 2; br_ctrl = 0; step();
        br_valid = 0; rf_gnt = 1; step();
        rf_gnt = 0; flush = 1; step();
        flush = 0;
        for (int k = 0; k < 4; k++) begin
            chk("flush_no_resp", 64'(resp_valid), 0);
            step();
        end
        chk("flush_cnt", 64'({cnt_branches, cnt_taken}), 0);

        for (int k = 0; k < 4; k++) run_br(32'h700, 1, 2, 13'h020, 3'd0, 0, 0, 0);
        chk("sat_branches", 64'(cnt_branches), 3);
        chk("sat_taken", 64'(cnt_taken), 3);
        run_br(32'h700, 1, 2, 13'h020, 3'd0, 0, 1, 1);
        chk("clr_hs_branches", 64'(cnt_branches), 0);
        chk("clr_hs_taken", 64'(cnt_taken), 0);

        // Asynchronous reset while a read request is outstanding.
        br_valid = 1; br_pc = 32'h800; step();
        br_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_rf_req", 64'(rf_req), 0);
        chk("arst_br_ready", 64'(br_ready), 1);
        chk("arst_resp_valid", 64'(resp_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        for (int n = 0; n < 3000; n++) begin
            br_valid   = ($urandom_range(0, 1) == 1);
            br_pc      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15)) : $urandom;
            br_rs1     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            br_rs2     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            br_imm     = 13'($urandom) & 13'h1FFE;
            br_ctrl    = 3'($urandom);
            rf_gnt     = ($urandom_range(0, 1) == 1);
            resp_ready = ($urandom_range(0, 1) == 1);
            flush      = ($urandom_range(0, 31) == 0);
            cnt_clr    = ($urandom_range(0, 31) == 0);
            step();
        end
        br_valid = 0; flush = 0; cnt_clr = 0; rf_gnt = 0; resp_ready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
